alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU and drives its `port_a`, `port_b` and `aluop` inputs. It captures decoded operands once per cycle, resolves EX/MEM and MEM/WB forwarding at capture time, and selects the immediate for `port_b` when requested. It also supports stall and flush, and flags load-use hazards to the hazard unit.

## Interface
Parameters:
- `WORD_W`, 32, data width; matches `word_t`.
- `REG_W`, 5, register index width.

Ports:
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `stall` in 1: hold all stage registers.
- `flush` in 1: insert a bubble.
- `in_valid` in 1: the decode slot holds a real instruction.
- `aluop_in` in `aluop_t` (4): decoded ALU operation.
- `rs_idx`, `rt_idx` in `REG_W`: source register indices.
- `rs_data`, `rt_data` in `WORD_W`: register file read data.
- `imm_ext` in `WORD_W`: immediate, already sign- or zero-extended by decode.
- `alu_src` in 1: 1 selects `imm_ext` for `port_b`; 0 selects forwarded rt.
- `exmem_wen` in 1, `exmem_load` in 1, `exmem_rd` in `REG_W`, `exmem_data` in `WORD_W`: EX/MEM writeback candidate.
- `memwb_wen` in 1, `memwb_rd` in `REG_W`, `memwb_data` in `WORD_W`: MEM/WB writeback candidate.
- `port_a`, `port_b` out `WORD_W`: registered ALU operands.
- `aluop` out `aluop_t`: registered ALU operation.
- `rt_fwd` out `WORD_W`: registered forwarded rt value, used as store data.
- `out_valid` out 1: the stage holds a real instruction.
- `hazard` out 1: combinational load-use hazard request.

## Operation
Forwarding is computed combinationally from current inputs, separately for rs and rt. For source index `s`:
- If `s != 0` and `exmem_wen` and `exmem_rd == s` and `!exmem_load`: take `exmem_data`.
- Else if `s != 0` and `memwb_wen` and `memwb_rd == s`: take `memwb_data`.
- Else: take the register file data.
- EX/MEM has priority over MEM/WB.
- Register 0 is never forwarded; the stage uses `rs_data`/`rt_data` as given.

`hazard = in_valid & exmem_wen & exmem_load & (exmem_rd != 0) & (exmem_rd == rs_idx | (exmem_rd == rt_idx & !alu_src))`.
- `hazard` does not alter the stage's behaviour.
- The hazard unit is expected to respond with `stall` or `flush`.

Register update priority at each rising edge of `CLK`, highest first:
- `RST`: all outputs cleared (see Timing).
- `flush`: `out_valid` = 0, `aluop` = 4'b0000, `port_a` = `port_b` = `rt_fwd` = 0.
- `stall`: every register holds its value.
- Otherwise: `port_a` = forwarded rs; `port_b` = `alu_src ? imm_ext : forwarded rt`; `rt_fwd` = forwarded rt; `aluop` = `aluop_in`; `out_valid` = `in_valid`.

When `in_valid` = 0 the operands are still captured, but `out_valid` = 0 and downstream ignores the stage.

## Timing
- Reset values: `port_a` = `port_b` = `rt_fwd` = 0, `aluop` = 4'b0000, `out_valid` = 0.
- `hazard` is combinational and has no reset value.
- `RST` asserted mid-operation clears the stage at the next edge regardless of `stall`/`flush`.
- Latency: inputs presented in cycle N appear on the outputs after edge N+1.
- No combinational path from inputs to `port_a`, `port_b`, `aluop`, `rt_fwd` or `out_valid`.
- `stall` and `flush` asserted together: flush wins.
- On release of a stall, the edge that deasserts it captures fresh inputs, including fresh forwarding decisions.
- A held operand is never re-forwarded during a stall.
- Simultaneous EX/MEM and MEM/WB writes to the same register forward the EX/MEM value.
- A matching EX/MEM load is not forwarded. The stage falls through to MEM/WB or the register file, and `hazard` is raised.

## Test plan
- Reset: hold `RST` for 2 cycles with random inputs -> all outputs 0, `out_valid` = 0. Release with `in_valid` = 1, `aluop_in` = 4'b0100, `rs_data` = 5, `rt_data` = 7 -> next edge `port_a` = 5, `port_b` = 7, `aluop` = 4'b0100, `out_valid` = 1.
- Forward priority: `rs_idx` = 3, `exmem_rd` = `memwb_rd` = 3, both wen, `exmem_data` = 32'hAAAA0000, `memwb_data` = 32'h5555 -> `port_a` = 32'hAAAA0000. Deassert `exmem_wen` -> `port_a` = 32'h5555.
- Register zero: `rs_idx` = 0, `exmem_rd` = 0, `exmem_wen` = 1, `exmem_data` = 32'hFFFFFFFF, `rs_data` = 0 -> `port_a` = 0.
- Immediate select: `alu_src` = 1, `imm_ext` = 32'hFFFF8000, `rt_idx` matches EX/MEM with `exmem_data` = 9 -> `port_b` = 32'hFFFF8000, `rt_fwd` = 9.
- Load-use: `exmem_load` = 1, `exmem_wen` = 1, `exmem_rd` = `rs_idx` = 4, `in_valid` = 1 -> `hazard` = 1 in the same cycle, and `exmem_data` is not forwarded. With `alu_src` = 1 and only `rt_idx` matching -> `hazard` = 0.
- Stall/flush: capture `port_a` = 12, then `stall` = 1 for 3 cycles with changing inputs -> `port_a` stays 12. Assert `stall` = `flush` = 1 -> `out_valid` = 0 and all operands 0 on the next edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU: resolves EX/MEM and MEM/WB forwarding
// for rs and rt at capture time, selects the immediate for port_b, supports
// stall/flush, and raises a combinational load-use hazard request.

package alu_operand_pkg;
  typedef logic [3:0] aluop_t;
endpackage

// One forwarding mux per source operand. EX/MEM beats MEM/WB; register 0
// and in-flight loads in EX/MEM are never forwarded.
module alu_operand_fwd #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_idx,
  input  logic [WORD_W-1:0] src_data,
  input  logic              exmem_wen,
  input  logic              exmem_load,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [WORD_W-1:0] exmem_data,
  input  logic              memwb_wen,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [WORD_W-1:0] memwb_data,
  output logic [WORD_W-1:0] fwd_data
);
  logic nz;
  assign nz = (src_idx != '0);

  // Priority select of the freshest non-load producer.
  always_comb begin
    fwd_data = src_data;
    if (nz && exmem_wen && !exmem_load && (exmem_rd == src_idx))
      fwd_data = exmem_data;
    else if (nz && memwb_wen && (memwb_rd == src_idx))
      fwd_data = memwb_data;
  end
endmodule

module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  aluop_t            aluop_in,
  input  logic [REG_W-1:0]  rs_idx,
  input  logic [REG_W-1:0]  rt_idx,
  input  logic [WORD_W-1:0] rs_data,
  input  logic [WORD_W-1:0] rt_data,
  input  logic [WORD_W-1:0] imm_ext,
  input  logic              alu_src,
  input  logic              exmem_wen,
  input  logic              exmem_load,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [WORD_W-1:0] exmem_data,
  input  logic              memwb_wen,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [WORD_W-1:0] memwb_data,
  output logic [WORD_W-1:0] port_a,
  output logic [WORD_W-1:0] port_b,
  output aluop_t            aluop,
  output logic [WORD_W-1:0] rt_fwd,
  output logic              out_valid,
  output logic              hazard
);
  localparam int NUM_SRC = 2; // lane 0 = rs, lane 1 = rt

  logic [NUM_SRC-1:0][REG_W-1:0]  src_idx;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_data;
  logic [NUM_SRC-1:0][WORD_W-1:0] fwd_data;

  assign src_idx  = {rt_idx, rs_idx};
  assign src_data = {rt_data, rs_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    alu_operand_fwd #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd (
      .src_idx    (src_idx[g]),
      .src_data   (src_data[g]),
      .exmem_wen  (exmem_wen),
      .exmem_load (exmem_load),
      .exmem_rd   (exmem_rd),
      .exmem_data (exmem_data),
      .memwb_wen  (memwb_wen),
      .memwb_rd   (memwb_rd),
      .memwb_data (memwb_data),
      .fwd_data   (fwd_data[g])
    );
  end

  // rt only matters for the hazard when port_b actually consumes it; store
  // data still goes through rt_fwd, but by then the load has reached MEM/WB.
  assign hazard = in_valid & exmem_wen & exmem_load & (exmem_rd != '0) &
                  ((exmem_rd == rs_idx) | ((exmem_rd == rt_idx) & ~alu_src));

  // Stage register: reset > flush > stall > capture. Forwarding is resolved
  // only on capture, so a held operand is never re-forwarded while stalled.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      port_a    <= '0;
      port_b    <= '0;
      rt_fwd    <= '0;
      aluop     <= 4'b0000;
      out_valid <= 1'b0;
    end else if (!stall) begin
      port_a    <= fwd_data[0];
      port_b    <= alu_src ? imm_ext : fwd_data[1];
      rt_fwd    <= fwd_data[1];
      aluop     <= aluop_in;
      out_valid <= in_valid;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;
  import alu_operand_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, stall, flush, in_valid, alu_src;
  aluop_t      aluop_in, aluop;
  logic [4:0]  rs_idx, rt_idx, exmem_rd, memwb_rd;
  logic [31:0] rs_data, rt_data, imm_ext, exmem_data, memwb_data;
  logic        exmem_wen, exmem_load, memwb_wen;
  logic [31:0] port_a, port_b, rt_fwd;
  logic        out_valid, hazard;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_operand_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .in_valid(in_valid),
    .aluop_in(aluop_in), .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .alu_src(alu_src),
    .exmem_wen(exmem_wen), .exmem_load(exmem_load), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .memwb_wen(memwb_wen), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .port_a(port_a), .port_b(port_b), .aluop(aluop),
    .rt_fwd(rt_fwd), .out_valid(out_valid), .hazard(hazard)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " port_a"}, port_a, 32'h0);
    check({tag, " port_b"}, port_b, 32'h0);
    check({tag, " rt_fwd"}, rt_fwd, 32'h0);
    check({tag, " aluop"}, {28'h0, aluop}, 32'h0);
    check({tag, " out_valid"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    // reset with random inputs for 2 cycles
    RST = 1'b1;
    stall = 1'($urandom); flush = 1'($urandom); in_valid = 1'b1;
    aluop_in = 4'($urandom); rs_idx = 5'($urandom); rt_idx = 5'($urandom);
    rs_data = $urandom; rt_data = $urandom; imm_ext = $urandom; alu_src = 1'($urandom);
    exmem_wen = 1'($urandom); exmem_load = 1'($urandom); exmem_rd = 5'($urandom);
    exmem_data = $urandom; memwb_wen = 1'($urandom); memwb_rd = 5'($urandom);
    memwb_data = $urandom;
    step(); step();
    check_cleared("reset");

    // release reset, first capture
    RST = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; aluop_in = 4'b0100;
    rs_idx = 5'd1; rt_idx = 5'd2; rs_data = 32'd5; rt_data = 32'd7; alu_src = 1'b0;
    exmem_wen = 1'b0; exmem_load = 1'b0; memwb_wen = 1'b0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check("no comb path port_a", port_a, 32'h0);
    step();
    check("first port_a", port_a, 32'd5);
    check("first port_b", port_b, 32'd7);
    check("first rt_fwd", rt_fwd, 32'd7);
    check("first aluop", {28'h0, aluop}, 32'h4);
    check("first out_valid", {31'h0, out_valid}, 32'h1);

    // EX/MEM beats MEM/WB on the same register
    rs_idx = 5'd3; exmem_rd = 5'd3; memwb_rd = 5'd3; exmem_wen = 1'b1; memwb_wen = 1'b1;
    exmem_data = 32'hAAAA0000; memwb_data = 32'h5555;
    step();
    check("prio exmem port_a", port_a, 32'hAAAA0000);
    check("prio rt untouched", port_b, 32'd7);
    exmem_wen = 1'b0;
    step();
    check("prio memwb port_a", port_a, 32'h5555);

    // MEM/WB forwarding on rt only
    rs_data = 32'h11; rt_idx = 5'd6; memwb_rd = 5'd6; memwb_data = 32'h1234;
    step();
    check("memwb rt port_a", port_a, 32'h11);
    check("memwb rt port_b", port_b, 32'h1234);
    check("memwb rt rt_fwd", rt_fwd, 32'h1234);

    // register zero is never forwarded
    rs_idx = 5'd0; rs_data = 32'h0; exmem_rd = 5'd0; exmem_wen = 1'b1;
    exmem_data = 32'hFFFFFFFF; memwb_rd = 5'd0; memwb_wen = 1'b1; memwb_data = 32'hEEEE;
    step();
    check("reg0 port_a", port_a, 32'h0);

    // immediate select, rt still forwarded into rt_fwd
    rs_idx = 5'd1; rs_data = 32'd5; alu_src = 1'b1; imm_ext = 32'hFFFF8000;
    rt_idx = 5'd5; exmem_rd = 5'd5; exmem_data = 32'd9; exmem_wen = 1'b1; memwb_wen = 1'b0;
    step();
    check("imm port_a", port_a, 32'd5);
    check("imm port_b", port_b, 32'hFFFF8000);
    check("imm rt_fwd", rt_fwd, 32'd9);

    // load-use on rs: hazard raised, load data not forwarded
    alu_src = 1'b0; exmem_load = 1'b1; exmem_wen = 1'b1; exmem_rd = 5'd4; rs_idx = 5'd4;
    rs_data = 32'h44; exmem_data = 32'hDEAD; rt_idx = 5'd1; rt_data = 32'h3; in_valid = 1'b1;
    #1;
    check("loaduse rs hazard", {31'h0, hazard}, 32'h1);
    step();
    check("loaduse rs port_a", port_a, 32'h44);
    memwb_wen = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h77;
    step();
    check("loaduse fallthrough memwb", port_a, 32'h77);
    memwb_wen = 1'b0;
    rs_idx = 5'd1; rs_data = 32'h10; rt_idx = 5'd4; alu_src = 1'b1;
    #1;
    check("loaduse rt imm no hazard", {31'h0, hazard}, 32'h0);
    alu_src = 1'b0;
    #1;
    check("loaduse rt hazard", {31'h0, hazard}, 32'h1);
    in_valid = 1'b0;
    #1;
    check("invalid no hazard", {31'h0, hazard}, 32'h0);
    step();
    check("invalid out_valid", {31'h0, out_valid}, 32'h0);
    check("invalid still captures", port_a, 32'h10);

    // stall holds, then stall+flush clears
    exmem_load = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0; in_valid = 1'b1;
    rs_idx = 5'd1; rs_data = 32'd12; rt_idx = 5'd2; rt_data = 32'd3; aluop_in = 4'b0101;
    step();
    check("pre-stall port_a", port_a, 32'd12);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'd100 + 32'(i); exmem_wen = 1'b1; exmem_rd = 5'd1; exmem_data = 32'hCC00 + 32'(i);
      aluop_in = 4'b1111; in_valid = 1'b0;
      step();
      check("stall port_a", port_a, 32'd12);
      check("stall aluop", {28'h0, aluop}, 32'h5);
      check("stall out_valid", {31'h0, out_valid}, 32'h1);
    end
    flush = 1'b1;
    step();
    check_cleared("stall+flush");

    // release: fresh capture with fresh forwarding
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1; rs_data = 32'h99;
    exmem_wen = 1'b1; exmem_rd = 5'd1; exmem_data = 32'hBB; aluop_in = 4'b0010;
    step();
    check("release port_a", port_a, 32'hBB);
    check("release out_valid", {31'h0, out_valid}, 32'h1);

    // reset mid-operation overrides stall
    RST = 1'b1; stall = 1'b1;
    step();
    check_cleared("mid reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
